// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the matching transmitter.
// Contents: receive FSM state encoding.
// No ports; import with uart_pkg::*.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Latency: 2 clk cycles from d to q.
// No backpressure; q is the settled copy of d.
// Ports: clk, rst (async active-high), d (async input), q (synchronized output).
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync2

// File: rtl/uart_rx.sv
// Serial receiver: mid-bit samples an idle-high line, LSB first, one stop bit.
// Latency: valid/frame_err/overrun assert the cycle after the stop sample.
// Backpressure: one-word holding register; a good frame arriving while it is full and not being read is dropped and flagged by overrun.
// Ports: clk, rst (async active-high), rxd (serial in), data/valid/ready (word stream),
//        frame_err (bad stop bit pulse), overrun (dropped word pulse).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);

    // Half-bit load puts the start sample in the middle of the start bit;
    // every later sample is then a whole bit period further on.
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic                 w_rxs;
    logic                 r_rxs_q;
    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    rx_state_t            w_state_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [IW-1:0]        w_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_tick;
    logic                 w_load;
    logic                 w_ferr;
    logic                 w_ovr;

    sync2 #(.RST_VAL(1'b1)) u_sync_rxd (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (w_rxs)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        w_ovr       = 1'b0;
        w_tick      = (r_cnt == '0);

        case (r_state)
            RX_IDLE: begin
                // Falling edge only: a line stuck low after a bad frame
                // cannot retrigger reception.
                if (r_rxs_q && !w_rxs) begin
                    w_state_nxt = RX_START;
                    w_cnt_nxt   = HALF_M1;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    if (!w_rxs) begin
                        w_state_nxt = RX_DATA;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = FULL_M1;
                    end else begin
                        // Line back high at mid start bit: a glitch, ignore it.
                        w_state_nxt = RX_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
                    w_cnt_nxt   = FULL_M1;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = RX_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    w_state_nxt = RX_IDLE;
                    if (w_rxs) begin
                        // Holding register is free if empty or drained this cycle.
                        if (!r_valid || ready) begin
                            w_load = 1'b1;
                        end else begin
                            w_ovr = 1'b1;
                        end
                    end else begin
                        w_ferr = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxs_q     <= 1'b1;
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rxs_q     <= w_rxs;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_ferr;
            r_overrun   <= w_ovr;
            if (w_load) begin
                r_data  <= w_shift_nxt;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule : uart_rx

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver (8N1-style, parameterizable data width) that deserializes a line driven by a matching serial transmitter into parallel words. It sits at the boundary between an external serial pin and the on-chip valid/ready stream. It oversamples the line with a per-bit clock counter, mid-bit samples each bit and flags framing and overrun errors.

## Interface

- CLKS_PER_BIT, 16, clk cycles per serial bit; must be ≥ 4 and even.
- DATA_BITS, 8, data bits per frame; legal range 5..9, LSB first on the line.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  serial line; idle high; asynchronous to clk.
- data  out  DATA_BITS  received word; reset 0; stable while valid=1.
- valid  out  1  word available; reset 0.
- ready  in  1  consumer accepts data when valid&&ready.
- frame_err  out  1  one-cycle pulse on bad stop bit; reset 0.
- overrun  out  1  one-cycle pulse when a good frame is dropped; reset 0.

## Operation

- rxd passes through a 2-flop synchronizer (flops reset to 1); rxs is the synchronized value, rxs_q its one-cycle delay (reset 1).
- Start detect: rxs_q=1 and rxs=0 while in RX_IDLE; call this cycle t0.
- States:
  - RX_IDLE: wait for start detect; load bit counter with CLKS_PER_BIT/2-1 -> RX_START.
  - RX_START: when counter=0 sample rxs; 0 -> RX_DATA, bit index 0, counter CLKS_PER_BIT-1; 1 (glitch) -> RX_IDLE, nothing reported.
  - RX_DATA: when counter=0 shift rxs into shift register MSB-ward (LSB first on line), reload counter; after bit DATA_BITS-1 -> RX_STOP.
  - RX_STOP: when counter=0 sample rxs; -> RX_IDLE in all cases.
- Stop=1: if valid=0 or ready=1 in that cycle, load data and set valid next cycle; else drop the new word, keep old data, pulse overrun.
- Stop=0: pulse frame_err; data/valid untouched. Next start needs a fresh 1->0 edge.
- valid clears on the cycle after valid&&ready unless a new word loads in the same cycle (then valid stays 1 with new data).
- rst at any time: all state to reset values, FSM to RX_IDLE, partial frame discarded.

## Timing

- Counters are free of off-by-one: start sample at t0+CLKS_PER_BIT/2, data bit k at t0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT, stop at t0+CLKS_PER_BIT/2+(DATA_BITS+1)·CLKS_PER_BIT.
- valid, frame_err, overrun assert in the cycle after the stop sample (registered outputs).
- rxd-to-rxs latency 2 cycles; defaults give valid at rxd falling edge + 2 + 8 + 144 + 1 cycles.
- Start detection possible immediately after stop sample (half stop bit of slack for back-to-back frames).
- Bit counter width $clog2(CLKS_PER_BIT); bit index width $clog2(DATA_BITS+1).

## Structure

- Package uart_pkg: typedef enum logic [1:0] rx_state_t {RX_IDLE, RX_START, RX_DATA, RX_STOP}; shared with the transmitter.
- Sub-module sync2 (2-flop synchronizer, parameterized reset value) instantiated once for rxd.
- Single uart_rx module otherwise; one always_ff for FSM/datapath, async reset in sensitivity list.

## Test plan

- Defaults, send 0xA5 with stop=1, ready=1 -> data=0xA5, valid high one cycle, 155 cycles after rxd falling edge; no error pulses.
- Send 0x3C with stop bit 0 -> frame_err one-cycle pulse at stop+1; valid stays 0; next frame 0x5A received correctly.
- rxd low for 4 cycles then high -> FSM returns to RX_IDLE at start sample; no valid, no errors.
- ready=0, frames 0x11 then 0x22 -> data=0x11 held with valid=1; overrun pulses once at second stop; then ready=1 -> valid drops next cycle.
- Assert rst during bit 3 of 0x7E -> valid=0, data=0 immediately; after release, frame 0xC3 -> data=0xC3.
- Back-to-back frames 0x01, 0x80, 0xFF with one stop bit each and ready held 1 -> three valid pulses in order, no errors.
